// File: rtl/kp_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: geometry, FSM states
// and the column priority helper.
package kp_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  localparam logic [ROWS-1:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE_DB
  } kp_state_t;

  // Lowest-index active-low column wins when several keys share the scanned row.
  function automatic logic [1:0] lowest_low(input logic [COLS-1:0] cols);
    lowest_low = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cols[i]) lowest_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchroniser for the asynchronous keypad column lines; resets to
// all-ones so an idle (pulled-up) keypad is seen during and after reset.
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows on a slow scan tick, debounces the
// first key found and reports press/hold/release for the clock's time-set logic.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter logic [25:0] SCAN_PERIOD    = 26'd26999,
  parameter int          DEBOUNCE_SCANS = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [COLS-1:0]  col_in,
  output logic [ROWS-1:0]  row_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_down,
  output logic             key_release
);

  localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_SCANS);

  logic [COLS-1:0]  col_s;
  logic [25:0]      tick_cnt_reg;
  logic             tick;
  kp_state_t        state_reg, state_next;
  logic [1:0]       row_sel_reg, row_sel_next;
  logic [1:0]       cand_col_reg, cand_col_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [ROWS-1:0]  row_out_reg;
  logic [KEY_W-1:0] key_code_reg, key_code_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_down_reg, key_down_next;
  logic             key_release_reg, key_release_next;
  logic             cand_low;

  col_sync #(.WIDTH(COLS)) u_col_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (col_in),
    .dout    (col_s)
  );

  assign tick = (tick_cnt_reg == SCAN_PERIOD);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) tick_cnt_reg <= '0;
    else         tick_cnt_reg <= tick ? 26'd0 : tick_cnt_reg + 26'd1;
  end

  // The row stays frozen outside IDLE, so the candidate's row is row_sel itself.
  assign cand_low = ~col_s[cand_col_reg];

  always_comb begin
    state_next       = state_reg;
    row_sel_next     = row_sel_reg;
    cand_col_next    = cand_col_reg;
    cnt_next         = cnt_reg;
    key_code_next    = key_code_reg;
    key_down_next    = key_down_reg;
    key_valid_next   = 1'b0;
    key_release_next = 1'b0;
    if (tick) begin
      unique case (state_reg)
        IDLE: begin
          if (col_s != '1) begin
            cand_col_next = lowest_low(col_s);
            cnt_next      = 8'd1;
            state_next    = DEBOUNCE;
          end else begin
            row_sel_next = row_sel_reg + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            if (cnt_reg + 8'd1 >= DB_MAX) begin
              cnt_next       = DB_MAX;
              state_next     = PRESSED;
              key_code_next  = {row_sel_reg, cand_col_reg};
              key_down_next  = 1'b1;
              key_valid_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end else begin
            cnt_next     = 8'd0;
            state_next   = IDLE;
            row_sel_next = row_sel_reg + 2'd1;
          end
        end
        PRESSED: begin
          if (!cand_low) begin
            cnt_next   = 8'd1;
            state_next = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!cand_low) begin
            if (cnt_reg + 8'd1 >= DB_MAX) begin
              cnt_next         = 8'd0;
              state_next       = IDLE;
              key_down_next    = 1'b0;
              key_release_next = 1'b1;
              row_sel_next     = row_sel_reg + 2'd1;
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end else begin
            state_next = PRESSED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg       <= IDLE;
      row_sel_reg     <= 2'd0;
      cand_col_reg    <= 2'd0;
      cnt_reg         <= 8'd0;
      row_out_reg     <= ROW_RESET;
      key_code_reg    <= '0;
      key_valid_reg   <= 1'b0;
      key_down_reg    <= 1'b0;
      key_release_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      row_sel_reg     <= row_sel_next;
      cand_col_reg    <= cand_col_next;
      cnt_reg         <= cnt_next;
      row_out_reg     <= ~(4'b0001 << row_sel_next);
      key_code_reg    <= key_code_next;
      key_valid_reg   <= key_valid_next;
      key_down_reg    <= key_down_next;
      key_release_reg <= key_release_next;
    end
  end

  assign row_out     = row_out_reg;
  assign key_code    = key_code_reg;
  assign key_valid   = key_valid_reg;
  assign key_down    = key_down_reg;
  assign key_release = key_release_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a physical key matrix on the row/column
// wires and compares every cycle against a per-scan-tick behavioural model.
module tb_keypad_scanner;

  localparam int D   = 4;  // debounce scans
  localparam int PER = 4;  // clocks per scan tick

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid, key_down, key_release;
  logic [15:0] keys = 16'h0000;  // bit r*4+c set = key at row r, column c held

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int         m_row, m_cand, m_cnt, edge_n;
  bit         m_held, exp_valid, exp_release;
  logic [3:0] exp_code;
  int         n_valid, n_release;

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          ticks;
    logic [3:0]  row;
    logic [3:0]  code;
    logic        down;
    int          valids;
    int          rels;
  } seg_t;

  seg_t tbl[10];

  always #5 sys_clk = ~sys_clk;

  keypad_scanner #(.SCAN_PERIOD(26'd3), .DEBOUNCE_SCANS(D)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .col_in      (col_in),
    .row_out     (row_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .key_release (key_release)
  );

  // Passive matrix: a held key shorts its column to its row when that row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_cand = 0; m_cnt = 0; m_held = 0;
    exp_valid = 0; exp_release = 0; exp_code = 4'd0; edge_n = 0;
  endtask

  // One scan tick: look at the driven row, then track agreement of the chosen key.
  task automatic model_tick();
    int low;
    bit any, down_now;
    any = 0; low = 0;
    for (int c = 3; c >= 0; c--) if (keys[m_row*4+c]) begin any = 1; low = c; end
    down_now = keys[m_cand];
    if (!m_held) begin
      if (m_cnt == 0) begin
        if (any) begin m_cand = m_row*4 + low; m_cnt = 1; end
        else m_row = (m_row + 1) % 4;
      end else if (down_now) begin
        m_cnt++;
        if (m_cnt == D) begin m_held = 1; m_cnt = 0; exp_code = 4'(m_cand); exp_valid = 1; end
      end else begin
        m_cnt = 0; m_row = (m_row + 1) % 4;
      end
    end else begin
      if (!down_now) begin
        m_cnt++;
        if (m_cnt == D) begin m_held = 0; m_cnt = 0; exp_release = 1; m_row = (m_row + 1) % 4; end
      end else begin
        m_cnt = 0;
      end
    end
  endtask

  task automatic step_cycle();
    logic [3:0] exp_row;
    @(posedge sys_clk);
    edge_n++;
    exp_valid = 0; exp_release = 0;
    if (edge_n % PER == 0) model_tick();
    @(negedge sys_clk);
    exp_row = 4'b0001 << m_row;
    check("row_out", row_out, ~exp_row);
    check("key_valid", 4'(key_valid), 4'(exp_valid));
    check("key_release", 4'(key_release), 4'(exp_release));
    check("key_down", 4'(key_down), 4'(m_held));
    check("key_code", key_code, exp_code);
    if (key_valid) n_valid++;
    if (key_release) n_release++;
  endtask

  task automatic apply(input logic [15:0] k, input int nticks);
    keys = k;
    repeat (nticks * PER) step_cycle();
  endtask

  task automatic do_reset(input string why);
    #2 sys_rst = 1'b1;
    #1;
    check({why, "_rst_row"}, row_out, 4'b1110);
    check({why, "_rst_code"}, key_code, 4'd0);
    check({why, "_rst_valid"}, 4'(key_valid), 4'd0);
    check({why, "_rst_down"}, 4'(key_down), 4'd0);
    check({why, "_rst_release"}, 4'(key_release), 4'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    $display("reset %s: row_out=%b key_code=%h down=%b", why, row_out, key_code, key_down);
  endtask

  initial begin
    int sel;
    int ev_valid, ev_rel;
    tbl[0] = '{"idle_scan",    16'h0000, 5, 4'b1101, 4'd0, 1'b0, 0, 0};
    tbl[1] = '{"press_k9",     16'h0200, 5, 4'b1011, 4'd9, 1'b1, 1, 0};
    tbl[2] = '{"rel_glitch",   16'h0000, 2, 4'b1011, 4'd9, 1'b1, 0, 0};
    tbl[3] = '{"repress_k9",   16'h0200, 2, 4'b1011, 4'd9, 1'b1, 0, 0};
    tbl[4] = '{"release_k9",   16'h0000, 4, 4'b0111, 4'd9, 1'b0, 0, 1};
    tbl[5] = '{"bounce_on_k7", 16'h0080, 4, 4'b1101, 4'd9, 1'b0, 0, 0};
    tbl[6] = '{"bounce_off",   16'h0000, 1, 4'b1011, 4'd9, 1'b0, 0, 0};
    tbl[7] = '{"multi_k0_k3",  16'h0009, 7, 4'b1110, 4'd0, 1'b1, 1, 0};
    tbl[8] = '{"multi_rel",    16'h0000, 4, 4'b1101, 4'd0, 1'b0, 0, 1};
    tbl[9] = '{"pre_rst_k5",   16'h0020, 2, 4'b1101, 4'd0, 1'b0, 0, 0};

    model_reset();
    @(negedge sys_clk);
    do_reset("power_on");

    for (int i = 0; i < 10; i++) begin
      n_valid = 0; n_release = 0;
      apply(tbl[i].keys, tbl[i].ticks);
      check({tbl[i].name, "_row"}, row_out, tbl[i].row);
      check({tbl[i].name, "_code"}, key_code, tbl[i].code);
      check({tbl[i].name, "_down"}, 4'(key_down), 4'(tbl[i].down));
      check_int({tbl[i].name, "_valids"}, n_valid, tbl[i].valids);
      check_int({tbl[i].name, "_releases"}, n_release, tbl[i].rels);
      $display("seg %s: keys=%h row_out=%b code=%h down=%b valids=%0d releases=%0d",
               tbl[i].name, tbl[i].keys, row_out, key_code, key_down, n_valid, n_release);
    end

    // Reset lands while key 5 is mid-debounce; nothing may be reported afterwards.
    do_reset("mid_debounce");
    check("post_rst_row", row_out, 4'b1110);
    n_valid = 0; n_release = 0;
    apply(16'h0000, 6);
    check_int("post_rst_valids", n_valid, 0);
    check("post_rst_code", key_code, 4'd0);
    check("post_rst_row6", row_out, 4'b1011);
    $display("seg post_reset_idle: row_out=%b valids=%0d", row_out, n_valid);

    // Random matrix activity; keys change only right after scan ticks.
    ev_valid = 0; ev_rel = 0;
    for (int t = 0; t < 400; t++) begin
      if (t == 200) do_reset("random_mid_run");
      sel = $urandom_range(0, 99);
      if (sel >= 80 && sel < 88)      keys = 16'h0000;
      else if (sel >= 88 && sel < 97) keys = 16'h0001 << $urandom_range(0, 15);
      else if (sel >= 97)             keys = 16'($urandom);
      n_valid = 0; n_release = 0;
      apply(keys, 1);
      if (n_valid != 0 || n_release != 0)
        $display("rand tick %0d: keys=%h code=%h valid=%0d release=%0d down=%b",
                 t, keys, key_code, n_valid, n_release, key_down);
      ev_valid += n_valid;
      ev_rel += n_release;
    end
    $display("random phase: presses=%0d releases=%0d", ev_valid, ev_rel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 matrix keypad by driving one row at a time and reading back the columns.
- Debounces the key and reports one key code per press with a single-cycle strobe, plus a held level and a release strobe.
- Feeds the time-set logic of the digital clock; runs from the 27 MHz board clock.

Parameters:
- SCAN_PERIOD, 26'd26999: scan tick every SCAN_PERIOD+1 clocks (1 kHz at 27 MHz).
- DEBOUNCE_SCANS, 8: consecutive agreeing scan ticks required to accept a press or a release (range 2..255).

Ports:
- sys_clk  in  1  system clock, 27 MHz.
- sys_rst  in  1  reset, asynchronous, active-high.
- col_in  in  4  keypad columns, active-low, externally pulled up, asynchronous to sys_clk.
- row_out  out  4  keypad rows, active-low, exactly one row low at any time.
- key_code  out  4  code of the accepted key, row*4+col; holds the last value.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_down  out  1  high from acceptance until the release is accepted.
- key_release  out  1  one-cycle pulse when a release is accepted.

Behaviour:
- Reset values (sys_rst high, any time, including mid-debounce):
  - row_out=4'b1110, row_sel=0.
  - key_code=0, key_valid=0, key_down=0, key_release=0.
  - tick counter=0, debounce count=0, state=IDLE.
  - Synchroniser flops=4'hF.
- Synchroniser: col_in passes through 2 flops to give col_s; all decisions use col_s only.
- Tick counter:
  - Counts 0..SCAN_PERIOD and wraps; tick is true in the cycle where count==SCAN_PERIOD.
  - Free-running in every state.
- Scanning: row_out is registered, ~(4'b0001<<row_sel). The columns are sampled only on tick, so the driven row has a full period to settle. row_sel advances (wrapping 3->0) only on tick in IDLE.
- Column selection: if several bits of col_s are low, the lowest column index wins. Multiple rows are never seen at once.
- FSM (all transitions on tick only):
  - IDLE:
    - If col_s != 4'hF, latch cand = {row_sel, lowest low column}, freeze row_sel, cnt=1, go to DEBOUNCE.
    - Otherwise advance row_sel.
  - DEBOUNCE:
    - If col_s[cand col]==0: cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED, set key_code=cand, key_down=1, and pulse key_valid in the next cycle.
    - If col_s[cand col]==1: go to IDLE, cnt=0, advance row_sel, and emit no outputs.
  - PRESSED:
    - Row stays frozen.
    - If col_s[cand col]==1: cnt=1, go to RELEASE_DB.
    - Changes on other columns are ignored.
  - RELEASE_DB:
    - If col_s[cand col]==1: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE, key_down=0, pulse key_release, advance row_sel.
    - If col_s[cand col]==0: go back to PRESSED, with no new key_valid and no key_release.
- Latency:
  - Press: if the key is low at the synchroniser output from tick T onward, key_valid is high in the cycle after tick T+(DEBOUNCE_SCANS-1) periods.
  - key_down rises in the same cycle as key_valid. key_code is valid at or before key_valid and stable while key_down=1.
- Pulses:
  - key_valid and key_release are exactly 1 cycle and never asserted together.
  - At most one key_valid per press.
- Counter widths: cnt is 8 bits and saturates at DEBOUNCE_SCANS. The tick counter is 26 bits.

Decomposition:
- Shared package (kp_pkg):
  - State encoding: IDLE, DEBOUNCE, PRESSED, RELEASE_DB.
  - KEY_W=4, ROWS=4, COLS=4.
  - Reset row pattern 4'b1110.
- One natural sub-module: col_sync, a 2-flop synchroniser, parameterised width, reset value all-ones.
- Tick generator and FSM stay in keypad_scanner.

Test Plan (bench uses SCAN_PERIOD=3, DEBOUNCE_SCANS=4):
1. Reset: assert sys_rst mid-run -> row_out=1110, key_code=0, key_valid=0, key_down=0, key_release=0 immediately; after release, scanning restarts at row 0.
2. Idle scan: col_in=4'hF -> row_out steps 1110, 1101, 1011, 0111, 1110, each held 4 clocks; no pulses.
3. Press row 2 col 1, held steady:
   - row_out freezes at 1011.
   - After the 4th agreeing tick: key_valid=1 for 1 cycle, key_code=9, key_down=1.
4. Bounce: row 1 col 3 pulled low for 2 ticks then high -> no key_valid; FSM returns to IDLE; scanning resumes at row 2.
5. Release with glitch:
   - While holding key 9, release for 2 ticks then press again -> no key_release, no second key_valid, key_down stays 1.
   - Then release steadily for 4 ticks -> key_release pulses once, key_down=0, scanning resumes.
6. Multi-key and mid-operation reset:
   - Row 0 cols 0 and 3 low together -> key_code=0.
   - Reset asserted during DEBOUNCE -> no key_valid, all outputs at their reset values.
